caesar_step_sequencer: RTL and testbench

//  Sequences the Caesar-cipher display datapath. On each 1 Hz tick it advances the

---
 rtl/caesar_step_sequencer_pkg.sv | 41 ++++
 rtl/caesar_step_sequencer_if.sv | 23 ++
 rtl/caesar_step_sequencer_shift_alu.sv | 31 +++
 rtl/caesar_step_sequencer.sv | 126 ++++++++++++
 tb/tb_caesar_step_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/caesar_step_sequencer_pkg.sv
// Shared constants, FSM encoding and BCD helper for the Caesar step sequencer.
package caesar_step_sequencer_pkg;

  localparam int ALPHA = 26;
  localparam int IDX_W = 5;
  localparam int BCD_W = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_STEP    = 3'd1,
    S_REDUCE  = 3'd2,
    S_CALC    = 3'd3,
    S_CONV1   = 3'd4,
    S_CONV2   = 3'd5,
    S_PRESENT = 3'd6
  } state_t;

  // Partial BCD conversion: tens digit so far plus the remainder still to split.
  typedef struct packed {
    logic [BCD_W-1:0] tens;
    logic [IDX_W-1:0] rem;
  } bcd_t;

  typedef struct packed {
    state_t           state;
    logic             pending;
    logic             first;
    logic [IDX_W-1:0] plain_idx;
  } dbg_t;

  function automatic bcd_t bcd_iter(input bcd_t x);
    bcd_t y;
    y = x;
    if (x.rem >= IDX_W'(10)) begin
      y.rem  = x.rem - IDX_W'(10);
      y.tens = x.tens + BCD_W'(1);
    end
    return y;
  endfunction

endpackage

// File: rtl/caesar_step_sequencer_if.sv
// Digit update bus from the sequencer to the seven-segment display side.
interface caesar_step_sequencer_if;
  import caesar_step_sequencer_pkg::*;

  logic [BCD_W-1:0] plain_tens;
  logic [BCD_W-1:0] plain_ones;
  logic [BCD_W-1:0] cipher_tens;
  logic [BCD_W-1:0] cipher_ones;
  // upd_valid rises with a complete digit set and stays high, with the digits
  // frozen, until a posedge where upd_ready is also high; that edge transfers it.
  logic             upd_valid;
  logic             upd_ready;

  modport master (
    output plain_tens, plain_ones, cipher_tens, cipher_ones, upd_valid,
    input  upd_ready
  );

  modport slave (
    input  plain_tens, plain_ones, cipher_tens, cipher_ones, upd_valid,
    output upd_ready
  );
endinterface

// File: rtl/caesar_step_sequencer_shift_alu.sv
// Combinational modulo-ALPHA shift of a letter index by a reduced key.
module caesar_shift_alu
  import caesar_step_sequencer_pkg::*;
(
  input  logic [IDX_W-1:0] plain,
  input  logic [IDX_W-1:0] key_r,
  input  logic             enc,
  output logic [IDX_W-1:0] s
);

  logic [IDX_W:0] w_sum;
  logic [IDX_W:0] w_diff;
  logic [IDX_W:0] w_res;

  assign w_sum  = {1'b0, plain} + {1'b0, key_r};
  assign w_diff = {1'b0, plain} - {1'b0, key_r};

  // Both operands are below ALPHA, so a single correction brings the result in range.
  always_comb begin
    w_res = w_sum;
    if (enc) begin
      if (w_sum >= (IDX_W+1)'(ALPHA)) w_res = w_sum - (IDX_W+1)'(ALPHA);
    end else begin
      w_res = w_diff;
      if (w_diff[IDX_W]) w_res = w_diff + (IDX_W+1)'(ALPHA);
    end
  end

  assign s = w_res[IDX_W-1:0];

endmodule

// File: rtl/caesar_step_sequencer.sv
// Steps the plaintext letter on each tick, shifts it by the key and presents
// BCD digits of both indices to the display through a valid/ready update.
module caesar_step_sequencer
  import caesar_step_sequencer_pkg::*;
(
  input  logic                    CLOCK_50,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    run,
  input  logic                    ENCRYPT,
  input  logic [IDX_W-1:0]        key,
  caesar_step_sequencer_if.master upd,
  output logic                    wrap,
  output logic                    overrun,
  output dbg_t                    dbg
);

  state_t           r_state, w_next;
  logic             r_pending, r_overrun, r_first, r_wrap, r_enc, r_valid;
  logic [IDX_W-1:0] r_plain, r_key, w_s;
  bcd_t             r_p, r_c, w_p_next, w_c_next;
  logic [BCD_W-1:0] r_pt, r_po, r_ct, r_co;
  logic             w_start, w_tick_busy;

  caesar_shift_alu u_alu (
    .plain (r_plain),
    .key_r (r_key),
    .enc   (r_enc),
    .s     (w_s)
  );

  assign w_p_next    = bcd_iter(r_p);
  assign w_c_next    = bcd_iter(r_c);
  assign w_start     = (tick && run) || r_pending;
  assign w_tick_busy = tick && run && (r_state != S_IDLE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_start) w_next = S_STEP;
      S_STEP:    w_next = S_REDUCE;
      S_REDUCE:  w_next = S_CALC;
      S_CALC:    w_next = S_CONV1;
      S_CONV1:   w_next = S_CONV2;
      S_CONV2:   w_next = S_PRESENT;
      S_PRESENT: if (upd.upd_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
      r_first   <= 1'b1;
      r_wrap    <= 1'b0;
      r_enc     <= 1'b0;
      r_valid   <= 1'b0;
      r_plain   <= '0;
      r_key     <= '0;
      r_p       <= '0;
      r_c       <= '0;
      r_pt      <= '0;
      r_po      <= '0;
      r_ct      <= '0;
      r_co      <= '0;
    end else begin
      r_state <= w_next;
      r_wrap  <= 1'b0;
      // A tick arriving while busy is remembered once; a second one is lost.
      if (r_state == S_IDLE && w_start) r_pending <= 1'b0;
      else if (w_tick_busy) begin
        if (r_pending) r_overrun <= 1'b1;
        else           r_pending <= 1'b1;
      end
      case (r_state)
        S_STEP: begin
          r_key <= key;
          r_enc <= ENCRYPT;
          if (r_first) begin
            r_first <= 1'b0;
            r_plain <= '0;
          end else if (r_plain == IDX_W'(ALPHA-1)) begin
            r_plain <= '0;
            r_wrap  <= 1'b1;
          end else begin
            r_plain <= r_plain + IDX_W'(1);
          end
        end
        S_REDUCE: if (r_key >= IDX_W'(ALPHA)) r_key <= r_key - IDX_W'(ALPHA);
        S_CALC: begin
          r_p <= '{tens: '0, rem: r_plain};
          r_c <= '{tens: '0, rem: w_s};
        end
        S_CONV1: begin
          r_p <= w_p_next;
          r_c <= w_c_next;
        end
        S_CONV2: begin
          // Final iteration lands straight in the output registers with valid.
          r_p     <= w_p_next;
          r_c     <= w_c_next;
          r_pt    <= w_p_next.tens;
          r_po    <= w_p_next.rem[BCD_W-1:0];
          r_ct    <= w_c_next.tens;
          r_co    <= w_c_next.rem[BCD_W-1:0];
          r_valid <= 1'b1;
        end
        S_PRESENT: if (upd.upd_ready) r_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign upd.plain_tens  = r_pt;
  assign upd.plain_ones  = r_po;
  assign upd.cipher_tens = r_ct;
  assign upd.cipher_ones = r_co;
  assign upd.upd_valid   = r_valid;
  assign wrap            = r_wrap;
  assign overrun         = r_overrun;
  assign dbg             = '{state: r_state, pending: r_pending, first: r_first,
                             plain_idx: r_plain};

endmodule

// File: tb/tb_caesar_step_sequencer.sv
// Randomized and directed bench for caesar_step_sequencer with a queue scoreboard.
module tb_caesar_step_sequencer;
  import caesar_step_sequencer_pkg::*;

  logic             clk = 1'b0;
  logic             rst, tick, run, enc;
  logic [IDX_W-1:0] key;
  logic             wrap, overrun;
  dbg_t             dbg;
  logic             rand_mode, dir_ready, rnd_ready;

  caesar_step_sequencer_if u_if ();
  assign u_if.upd_ready = rand_mode ? rnd_ready : dir_ready;

  caesar_step_sequencer dut (
    .CLOCK_50 (clk),
    .rst      (rst),
    .tick     (tick),
    .run      (run),
    .ENCRYPT  (enc),
    .key      (key),
    .upd      (u_if.master),
    .wrap     (wrap),
    .overrun  (overrun),
    .dbg      (dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- scoreboard state ----------------
  logic [16:0] exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          hs_count = 0;
  int          wrap_seen = 0;
  int          last_wrap = 0;
  int          m_plain = 0;
  bit          m_first = 1'b1;
  bit          prev_valid = 1'b0;
  logic [15:0] held;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] pack_exp(input int p, input int c, input bit w);
    return {w, 4'(p / 10), 4'(p % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  // Reference model: one accepted tick = one new letter and its shifted partner.
  task automatic push_expected(input int k, input bit e);
    bit w;
    int c;
    w = 1'b0;
    if (m_first) begin
      m_first = 1'b0;
      m_plain = 0;
    end else begin
      w = (m_plain == 25);
      m_plain = (m_plain + 1) % 26;
    end
    c = e ? (m_plain + k % 26) % 26 : (m_plain - k % 26 + 26) % 26;
    exp_q.push_back(pack_exp(m_plain, c, w));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [15:0] cur;
    logic [16:0] e;
    if (rst) begin
      wrap_seen  = 0;
      prev_valid = 1'b0;
    end else begin
      if (wrap) wrap_seen++;
      cur = {u_if.plain_tens, u_if.plain_ones, u_if.cipher_tens, u_if.cipher_ones};
      if (u_if.upd_valid) begin
        if (prev_valid) check("held_digits", int'(cur), int'(held));
        held = cur;
        prev_valid = 1'b1;
        if (u_if.upd_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_update", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("digits", int'(cur), int'(e[15:0]));
            check("wrap_count", wrap_seen, int'(e[16]));
          end
          last_wrap  = wrap_seen;
          wrap_seen  = 0;
          prev_valid = 1'b0;
          hs_count++;
        end
      end else begin
        prev_valid = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
  endtask

  task automatic wait_hs(input int target);
    int t;
    t = 0;
    while (hs_count < target && t < 400) begin
      cyc(1);
      t++;
    end
    check("handshake_reached", hs_count, target);
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (!u_if.upd_valid && t < 50) begin
      cyc(1);
      t++;
    end
    check("valid_reached", int'(u_if.upd_valid), 1);
  endtask

  // Key changes two cycles after the tick is taken, i.e. while the step is in CALC.
  task automatic do_step(input int k, input bit e, input int k_after);
    int n;
    n = hs_count;
    key = IDX_W'(k);
    enc = e;
    push_expected(k, e);
    pulse_tick();
    cyc(2);
    key = IDX_W'(k_after);
    wait_hs(n + 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    exp_q.delete();
    m_first = 1'b1;
    m_plain = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, int'(u_if.upd_valid), 0);
    check({tag, "_digits"}, int'({u_if.plain_tens, u_if.plain_ones,
                                   u_if.cipher_tens, u_if.cipher_ones}), 0);
    check({tag, "_overrun"}, int'(overrun), 0);
    check({tag, "_state"}, int'(dbg.state), int'(S_IDLE));
  endtask

  task automatic check_out(input string tag, input int pt, input int po, input int ct, input int co);
    check({tag, "_pt"}, int'(u_if.plain_tens), pt);
    check({tag, "_po"}, int'(u_if.plain_ones), po);
    check({tag, "_ct"}, int'(u_if.cipher_tens), ct);
    check({tag, "_co"}, int'(u_if.cipher_ones), co);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, n;
    rst = 1'b1; tick = 1'b0; run = 1'b1; enc = 1'b1; key = '0;
    rand_mode = 1'b0; dir_ready = 1'b1;
    do_reset();
    check_idle_outputs("reset");
    check("reset_pending", int'(dbg.pending), 0);
    check("reset_wrap", int'(wrap), 0);

    // 1: first step latency and index 00
    key = 5'd3; enc = 1'b1;
    n = hs_count;
    push_expected(3, 1'b1);
    tick = 1'b1;
    lat = 0;
    do begin
      cyc(1);
      lat++;
      if (lat == 1) tick = 1'b0;
    end while (!u_if.upd_valid && lat < 20);
    check("latency", lat, 6);
    wait_hs(n + 1);
    check_out("t1", 0, 0, 0, 3);

    // 2: walk to 24, then 25, then wrap to 0
    rand_mode = 1'b1;
    while (m_plain != 24) do_step(3, 1'b1, 3);
    do_step(3, 1'b1, 3);
    check_out("t2_25", 2, 5, 0, 2);
    check("t2_no_wrap", last_wrap, 0);
    do_step(3, 1'b1, 3);
    check_out("t2_wrap", 0, 0, 0, 3);
    check("t2_wrap", last_wrap, 1);

    // 3: key reduction boundaries
    while (m_plain != 1) do_step($urandom_range(0, 31), 1'b1, 0);
    do_step(31, 1'b0, 31);
    check_out("t3_dec31", 0, 2, 2, 3);
    while (m_plain != 6) do_step($urandom_range(0, 31), 1'b0, 0);
    do_step(26, 1'b1, 26);
    check_out("t3_enc26", 0, 7, 0, 7);

    // 4: stalled display, one pended tick, one lost tick
    rand_mode = 1'b0; dir_ready = 1'b0;
    n = hs_count;
    key = 5'd4; enc = 1'b1;
    push_expected(4, 1'b1);
    pulse_tick();
    wait_valid();
    cyc(3);
    push_expected(4, 1'b1);
    pulse_tick();
    cyc(1);
    pulse_tick();
    cyc(15);
    check("t4_pending", int'(dbg.pending), 1);
    check("t4_overrun", int'(overrun), 1);
    check("t4_no_hs", hs_count, n);
    dir_ready = 1'b1;
    wait_hs(n + 2);
    check("t4_overrun_sticky", int'(overrun), 1);

    // 7: ready and tick together in PRESENT
    dir_ready = 1'b0;
    n = hs_count;
    key = 5'd11; enc = 1'b0;
    push_expected(11, 1'b0);
    pulse_tick();
    wait_valid();
    cyc(2);
    push_expected(11, 1'b0);
    dir_ready = 1'b1;
    pulse_tick();
    check("t7_pending", int'(dbg.pending), 1);
    wait_hs(n + 2);

    // 5: reset during CONV1
    check("t5_queue_empty", exp_q.size(), 0);
    key = 5'd7; enc = 1'b1;
    pulse_tick();
    cyc(3);
    check("t5_in_conv1", int'(dbg.state), int'(S_CONV1));
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    exp_q.delete();
    m_first = 1'b1;
    m_plain = 0;
    check_idle_outputs("t5");
    do_step(5, 1'b1, 5);
    check_out("t5_after", 0, 0, 0, 5);

    // 6: key change mid-step, then run=0 ignores ticks
    do_step(3, 1'b1, 9);
    check_out("t6_key", 0, 1, 0, 4);
    run = 1'b0;
    n = hs_count;
    for (int i = 0; i < 10; i++) begin
      pulse_tick();
      cyc(4);
    end
    check("t6_no_hs", hs_count, n);
    check("t6_plain", int'(dbg.plain_idx), m_plain);
    check("t6_no_pending", int'(dbg.pending), 0);
    run = 1'b1;

    // random phase
    rand_mode = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        run = 1'b0;
        n = hs_count;
        pulse_tick();
        cyc(8);
        check("rand_run0", hs_count, n);
        run = 1'b1;
      end else begin
        do_step($urandom_range(0, 31), 1'($urandom_range(0, 1)), $urandom_range(0, 31));
      end
      cyc($urandom_range(0, 3));
    end

    cyc(5);
    check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
